// File: rtl/bytebeat_poly.sv
`default_nettype none
// ============================================================================
// Module   : bytebeat_poly
// Brief    : Multi-voice bytebeat generator; one voice per clock through a
//            shared datapath, voices averaged into a ready/valid sample.
//            Optional macro BYTEBEAT_TSTEP_EN adds a programmable t increment.
// Revision : 1.0 - initial release
// ============================================================================
module bytebeat_poly #(
    parameter int VOICES   = 4,
    parameter int T_W      = 16,
    parameter int SAMPLE_W = 8,
    parameter int PARAM_W  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [VOICES*4*PARAM_W-1:0]   voice_params,
    input  logic [2*VOICES-1:0]           voice_mode,
    input  logic [VOICES-1:0]             voice_en,
    input  logic                          t_clear,
`ifdef BYTEBEAT_TSTEP_EN
    input  logic [PARAM_W-1:0]            t_step,
`endif
    output logic [SAMPLE_W-1:0]           output_s,
    output logic                          output_vld,
    input  logic                          output_rdy,
    output logic [T_W-1:0]                t_out
);

    localparam int c_log2v  = $clog2(VOICES);
    localparam int c_acc_w  = SAMPLE_W + c_log2v;
    localparam int c_vidx_w = (VOICES > 1) ? c_log2v : 1;
    localparam int c_cfg_w  = 4 * PARAM_W;

    typedef enum logic [0:0] {
        S_CALC = 1'b0,
        S_OUT  = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [c_vidx_w-1:0]         r_vidx;
    logic [T_W-1:0]              r_t;
    logic [c_acc_w-1:0]          r_acc;
    logic [VOICES*c_cfg_w-1:0]   r_params;
    logic [2*VOICES-1:0]         r_mode;
    logic [VOICES-1:0]           r_en;
    logic                        r_clr_pend;
    logic [SAMPLE_W-1:0]         r_sample;
    logic                        r_vld;

    logic                        w_first;
    logic                        w_last;
    logic                        w_hs;
    logic [VOICES*c_cfg_w-1:0]   w_params_src;
    logic [2*VOICES-1:0]         w_mode_src;
    logic [VOICES-1:0]           w_en_src;
    logic [c_cfg_w-1:0]          w_cfg;
    logic [PARAM_W-1:0]          w_a, w_b, w_c, w_d;
    logic [1:0]                  w_mode_v;
    logic                        w_en_v;
    logic [T_W-1:0]              w_ta;
    logic [T_W-1:0]              w_f;
    logic [SAMPLE_W-1:0]         w_res;
    logic [c_acc_w-1:0]          w_sum;
    logic [T_W-1:0]              w_step;

    assign w_first = (r_vidx == '0);
    assign w_last  = (r_vidx == c_vidx_w'(VOICES - 1));
    assign w_hs    = (r_state == S_OUT) && r_vld && output_rdy;

    // Voice 0 is evaluated in the snapshot cycle, so it reads the live inputs
    // that are being captured; later voices read the frozen copy.
    assign w_params_src = w_first ? voice_params : r_params;
    assign w_mode_src   = w_first ? voice_mode   : r_mode;
    assign w_en_src     = w_first ? voice_en     : r_en;

    assign w_cfg    = w_params_src[r_vidx*c_cfg_w +: c_cfg_w];
    assign w_a      = w_cfg[0*PARAM_W +: PARAM_W];
    assign w_b      = w_cfg[1*PARAM_W +: PARAM_W];
    assign w_c      = w_cfg[2*PARAM_W +: PARAM_W];
    assign w_d      = w_cfg[3*PARAM_W +: PARAM_W];
    assign w_mode_v = w_mode_src[r_vidx*2 +: 2];
    assign w_en_v   = w_en_src[r_vidx];

    // Logical right shifts by T_W or more already produce zero.
    always_comb begin
        w_ta = r_t * T_W'(w_a);
        w_f  = '0;
        case (w_mode_v)
            2'd0:    w_f = w_ta & (r_t >> w_b);
            2'd1:    w_f = w_ta | (r_t >> w_c);
            2'd2:    w_f = r_t * (((r_t >> w_b) | (r_t >> w_c)) & T_W'(w_d));
            default: w_f = w_ta ^ (r_t >> w_d);
        endcase
    end

    assign w_res = w_en_v ? SAMPLE_W'(w_f) : '0;
    assign w_sum = (w_first ? '0 : r_acc) + c_acc_w'(w_res);

`ifdef BYTEBEAT_TSTEP_EN
    logic [PARAM_W-1:0] r_t_step;
    assign w_step = T_W'(r_t_step);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_t_step <= '0;
        end else if (r_state == S_CALC && w_first) begin
            r_t_step <= t_step;
        end
    end
`else
    assign w_step = T_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_CALC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CALC:  if (w_last) w_state_nxt = S_OUT;
            S_OUT:   if (w_hs)   w_state_nxt = S_CALC;
            default: w_state_nxt = S_CALC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vidx     <= '0;
            r_t        <= '0;
            r_acc      <= '0;
            r_params   <= '0;
            r_mode     <= '0;
            r_en       <= '0;
            r_clr_pend <= 1'b0;
            r_sample   <= '0;
            r_vld      <= 1'b0;
        end else begin
            if (t_clear) begin
                r_clr_pend <= 1'b1;
            end
            if (r_state == S_CALC) begin
                if (w_first) begin
                    r_params <= voice_params;
                    r_mode   <= voice_mode;
                    r_en     <= voice_en;
                end
                r_acc <= w_sum;
                if (w_last) begin
                    r_sample <= SAMPLE_W'(w_sum >> c_log2v);
                    r_vld    <= 1'b1;
                    r_vidx   <= '0;
                end else begin
                    r_vidx <= r_vidx + c_vidx_w'(1);
                end
            end else if (w_hs) begin
                // A clear seen in the handshake cycle itself still wins.
                r_vld      <= 1'b0;
                r_t        <= (t_clear || r_clr_pend) ? '0 : r_t + w_step;
                r_clr_pend <= 1'b0;
            end
        end
    end

    assign output_s   = r_sample;
    assign output_vld = r_vld;
    assign t_out      = r_t;

endmodule
`default_nettype wire

// File: tb/tb_bytebeat_poly.sv
`default_nettype none
// ============================================================================
// Module   : tb_bytebeat_poly
// Brief    : Self-checking bench for bytebeat_poly (table vectors, random
//            sweep against an arithmetic reference model, directed corners).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bytebeat_poly;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] voice_params;
    logic [7:0]  voice_mode;
    logic [3:0]  voice_en;
    logic        t_clear;
    logic [7:0]  output_s;
    logic        output_vld;
    logic        output_rdy;
    logic [15:0] t_out;

    logic        reset_n2;
    logic [63:0] params2;
    logic [7:0]  mode2;
    logic [3:0]  en2;
    logic        t_clear2;
    logic [3:0]  s2;
    logic        vld2;
    logic        rdy2;
    logic [3:0]  tout2;

`ifdef BYTEBEAT_TSTEP_EN
    logic [3:0]  t_step;
    logic [3:0]  t_step2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bytebeat_poly #(.VOICES(4), .T_W(16), .SAMPLE_W(8), .PARAM_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .voice_params(voice_params),
        .voice_mode(voice_mode), .voice_en(voice_en), .t_clear(t_clear),
`ifdef BYTEBEAT_TSTEP_EN
        .t_step(t_step),
`endif
        .output_s(output_s), .output_vld(output_vld), .output_rdy(output_rdy),
        .t_out(t_out)
    );

    bytebeat_poly #(.VOICES(4), .T_W(4), .SAMPLE_W(4), .PARAM_W(4)) dut_w4 (
        .clk(clk), .reset_n(reset_n2), .voice_params(params2),
        .voice_mode(mode2), .voice_en(en2), .t_clear(t_clear2),
`ifdef BYTEBEAT_TSTEP_EN
        .t_step(t_step2),
`endif
        .output_s(s2), .output_vld(vld2), .output_rdy(rdy2),
        .t_out(tout2)
    );

    typedef struct {
        int         a, b, c, d, mode;
        logic [3:0] en;
        int         exp;
    } vec_t;

    vec_t tbl[6];

    function automatic int shr(int v, int s, int tw);
        return (s >= tw) ? 0 : (v >> s);
    endfunction

    // Mean of the four voice formulas, evaluated at width tw, truncated to sw.
    function automatic int model(int t, logic [63:0] p, logic [7:0] m,
                                 logic [3:0] en, int tw, int sw);
        int mask, smask, sum, a, b, c, d, f;
        mask  = (1 << tw) - 1;
        smask = (1 << sw) - 1;
        sum   = 0;
        for (int v = 0; v < 4; v++) begin
            a = int'(p[v*16 +: 4]);
            b = int'(p[v*16+4 +: 4]);
            c = int'(p[v*16+8 +: 4]);
            d = int'(p[v*16+12 +: 4]);
            case (int'(m[v*2 +: 2]))
                0:       f = ((t * a) & mask) & shr(t, b, tw);
                1:       f = ((t * a) & mask) | shr(t, c, tw);
                2:       f = (t * ((shr(t, b, tw) | shr(t, c, tw)) & d)) & mask;
                default: f = ((t * a) & mask) ^ shr(t, d, tw);
            endcase
            if (en[v]) sum += f & smask;
        end
        return sum / 4;
    endfunction

    function automatic logic [63:0] rep_params(int a, int b, int c, int d);
        logic [15:0] s;
        s = {d[3:0], c[3:0], b[3:0], a[3:0]};
        return {4{s}};
    endfunction

    function automatic logic [7:0] rep_mode(int m);
        return {4{m[1:0]}};
    endfunction

    task automatic check(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_vld();
        int n;
        n = 0;
        while (!output_vld && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!output_vld) begin
            n_tests++;
            n_fail++;
            $display("FAIL vld_timeout: got vld=0 expected vld=1 within 40 cycles");
        end
    endtask

    task automatic take();
        output_rdy = 1'b1;
        @(negedge clk);
        output_rdy = 1'b0;
    endtask

    initial begin
        logic [63:0] sp;
        logic [7:0]  sm;
        logic [3:0]  se;
        int          cnt, exp_t, s0, t0, stable, n;

        reset_n = 1'b0; reset_n2 = 1'b0;
        output_rdy = 1'b0; rdy2 = 1'b1;
        voice_params = '0; voice_mode = '0; voice_en = '0; t_clear = 1'b0;
        params2 = rep_params(3, 1, 5, 2); mode2 = 8'b11_10_01_00;
        en2 = 4'hF; t_clear2 = 1'b0;
`ifdef BYTEBEAT_TSTEP_EN
        t_step = 4'd1; t_step2 = 4'd1;
`endif
        tbl[0] = '{5, 0, 3, 0, 1, 4'hF, 8'h52};
        tbl[1] = '{5, 0, 3, 0, 1, 4'h1, 8'h15};
        tbl[2] = '{7, 1, 0, 0, 0, 4'hF, 8'h08};
        tbl[3] = '{2, 0, 0, 2, 3, 4'hF, 8'h22};
        tbl[4] = '{0, 1, 2, 15, 2, 4'hF, 8'h2C};
        tbl[5] = '{5, 0, 3, 0, 1, 4'h3, 8'h35};

        // Reset and first-sample latency
        repeat (2) @(negedge clk);
        check("rst_s", int'(output_s), 0);
        check("rst_vld", int'(output_vld), 0);
        check("rst_t", int'(t_out), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_early_vld", int'(output_vld), 0);
        @(negedge clk);
        check("lat_vld", int'(output_vld), 1);
        check("lat_s", int'(output_s), 0);
        check("lat_t", int'(t_out), 0);

        // Free-running with rdy high: period and t sequence
        output_rdy = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!output_vld && cnt < 20);
            check("period", cnt, 5);
            check("t_seq", int'(t_out), k);
        end

        // Table vectors, t = 16..21
        for (int i = 0; i < 6; i++) begin
            voice_params = rep_params(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
            voice_mode   = rep_mode(tbl[i].mode);
            voice_en     = tbl[i].en;
            sp = voice_params; sm = voice_mode; se = voice_en;
            take();
            wait_vld();
            check("tbl_s", int'(output_s), tbl[i].exp);
            check("tbl_model", int'(output_s), model(16 + i, sp, sm, se, 16, 8));
            check("tbl_t", int'(t_out), 16 + i);
        end

        // Backpressure: held sample stays put while inputs churn
        s0 = int'(output_s); t0 = int'(t_out); stable = 1;
        for (int i = 0; i < 10; i++) begin
            voice_params = {$urandom, $urandom};
            voice_mode   = 8'($urandom);
            voice_en     = 4'($urandom);
            @(negedge clk);
            if (!output_vld || int'(output_s) != s0 || int'(t_out) != t0) stable = 0;
        end
        check("hold_stable", stable, 1);
        sp = voice_params; sm = voice_mode; se = voice_en;
        take();
        wait_vld();
        check("hold_next_s", int'(output_s), model(t0 + 1, sp, sm, se, 16, 8));

        // Random sweep with mid-frame input scrambling and random backpressure
        for (int i = 0; i < 2000; i++) begin
            voice_params = {$urandom, $urandom};
            voice_mode   = 8'($urandom);
            voice_en     = 4'($urandom);
            sp = voice_params; sm = voice_mode; se = voice_en;
            exp_t = (int'(t_out) + 1) & 16'hFFFF;
            take();
            @(negedge clk);
            voice_params = {$urandom, $urandom};
            voice_mode   = 8'($urandom);
            voice_en     = 4'($urandom);
            wait_vld();
            check("rand_s", int'(output_s), model(exp_t, sp, sm, se, 16, 8));
            check("rand_t", int'(t_out), exp_t);
            n = $urandom_range(0, 2);
            repeat (n) @(negedge clk);
        end

        // t_clear while holding: sample untouched, next frame at t=0
        voice_params = rep_params(5, 0, 3, 0); voice_mode = rep_mode(1);
        voice_en = 4'hF;
        sp = voice_params; sm = voice_mode; se = voice_en;
        s0 = int'(output_s); t0 = int'(t_out);
        t_clear = 1'b1; @(negedge clk); t_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_hold_s", int'(output_s), s0);
        check("clr_hold_t", int'(t_out), t0);
        take();
        wait_vld();
        check("clr_t", int'(t_out), 0);
        check("clr_s", int'(output_s), model(0, sp, sm, se, 16, 8));

        // t_clear during CALC: current frame keeps its t
        take();
        @(negedge clk);
        t_clear = 1'b1; @(negedge clk); t_clear = 1'b0;
        wait_vld();
        check("clr_calc_t", int'(t_out), 1);
        check("clr_calc_s", int'(output_s), model(1, sp, sm, se, 16, 8));
        take();
        wait_vld();
        check("clr_calc_next_t", int'(t_out), 0);

        // Reset at vidx=2 discards the partial frame
        take();
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_s", int'(output_s), 0);
        check("midrst_vld", int'(output_vld), 0);
        check("midrst_t", int'(t_out), 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_relat_vld", int'(output_vld), 1);
        check("midrst_relat_s", int'(output_s), model(0, sp, sm, se, 16, 8));

        // Narrow counter (T_W=4): wraps 15 -> 0, shifts >= 4 give zero
        @(negedge clk);
        reset_n2 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            n = 0;
            while (!vld2 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("w4_t", int'(tout2), k % 16);
            check("w4_s", int'(s2), model(k % 16, params2, mode2, en2, 4, 4));
            @(negedge clk);
        end

`ifdef BYTEBEAT_TSTEP_EN
        // t_step = 3, then t_step = 0 freezes t
        reset_n = 1'b0; output_rdy = 1'b0; t_step = 4'd3;
        @(negedge clk);
        reset_n = 1'b1;
        wait_vld();
        output_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("step3_t", int'(t_out), 3 * k);
            if (k == 3) t_step = 4'd0;
            @(negedge clk);
            wait_vld();
        end
        s0 = int'(output_s);
        for (int k = 0; k < 3; k++) begin
            check("step0_t", int'(t_out), 12);
            check("step0_s", int'(output_s), s0);
            @(negedge clk);
            wait_vld();
        end
        output_rdy = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
